// File: rtl/emu_clk_sched_if.sv
`default_nettype none
// ============================================================================
// emu_clk_sched_if : host command channel (valid/ready) of the emu run-control
// Rev 1.0
// ============================================================================
interface emu_clk_sched_if #(
  parameter int unsigned STEP_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/emu_clk_sched.sv
`default_nettype none
// ============================================================================
// emu_clk_sched : run/pause/step/reset scheduler gating the emulator via a
// registered clock-enable. Optional stop-time feature: EMU_STOP_TIME_EN.
// Rev 1.0
// ============================================================================
module emu_clk_sched #(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned STEP_W     = 32,
  parameter int unsigned CNT_W      = 64
) (
  input  logic               emu_clk,
  input  logic               emu_rst,
  input  logic               locked,
  emu_clk_sched_if.slave     cmd,
`ifdef EMU_STOP_TIME_EN
  input  logic               stop_en,
  input  logic [CNT_W-1:0]   stop_time,
`endif
  output logic               dut_rst,
  output logic               emu_clk_en,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RUN     = 3'd2,
    ST_STEP    = 3'd3,
    ST_STOPPED = 3'd4
  } state_e;

  localparam logic [1:0] c_op_pause = 2'b00;
  localparam logic [1:0] c_op_run   = 2'b01;
  localparam logic [1:0] c_op_step  = 2'b10;

  localparam int unsigned         c_hold_w    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RST_CYCLES - 1);
  localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
  localparam logic [STEP_W-1:0]   c_step_one  = STEP_W'(1);

  state_e              state_q, state_d;
  logic                locked_meta_q, locked_meta_d;
  logic                locked_sync_q, locked_sync_d;
  logic [c_hold_w-1:0] hold_cnt_q, hold_cnt_d;
  logic [STEP_W-1:0]   step_rem_q, step_rem_d;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic                clk_en_q, clk_en_d;
  logic                dut_rst_q, dut_rst_d;
  logic                pend_q, pend_d;
  logic [1:0]          pend_op_q, pend_op_d;
  logic [STEP_W-1:0]   pend_arg_q, pend_arg_d;

  logic                w_cmd_fire;
  logic                w_cmd_live;
  logic                w_stop_hit;
  logic [CNT_W-1:0]    w_cycle_cnt_nxt;

  assign cmd.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) ||
                         (state_q == ST_STEP) || (state_q == ST_STOPPED);
  assign w_cmd_fire    = cmd.cmd_valid && cmd.cmd_ready;

  // Count value after this edge; the stop check looks at it so the counter
  // lands exactly on stop_time rather than one past it.
  assign w_cycle_cnt_nxt = cycle_cnt_q + CNT_W'(clk_en_q);

`ifdef EMU_STOP_TIME_EN
  assign w_stop_hit = stop_en && (w_cycle_cnt_nxt >= stop_time);
`else
  assign w_stop_hit = 1'b0;
`endif

  // A command captured last cycle is applied now; STOPPED only honours RESET.
  assign w_cmd_live = pend_q &&
                      ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_STEP) ||
                       ((state_q == ST_STOPPED) && (pend_op_q == 2'b11)));

  always_comb begin
    locked_meta_d = locked;
    locked_sync_d = locked_meta_q;
    state_d       = state_q;
    clk_en_d      = 1'b0;
    hold_cnt_d    = hold_cnt_q;
    step_rem_d    = step_rem_q;
    cycle_cnt_d   = w_cycle_cnt_nxt;
    pend_d        = w_cmd_fire;
    pend_op_d     = w_cmd_fire ? cmd.cmd_op  : pend_op_q;
    pend_arg_d    = w_cmd_fire ? cmd.cmd_arg : pend_arg_q;

    case (state_q)
      ST_HOLD: begin
        if (!locked_sync_q) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == c_hold_last) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + c_hold_one;
        end
      end
      ST_IDLE: begin
        clk_en_d = 1'b0;
      end
      ST_RUN: begin
        if (w_stop_hit) begin
          state_d = ST_STOPPED;
        end else begin
          clk_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (w_stop_hit) begin
          state_d    = ST_STOPPED;
          step_rem_d = '0;
        end else if (step_rem_q == c_step_one) begin
          state_d    = ST_IDLE;
          step_rem_d = '0;
        end else begin
          step_rem_d = step_rem_q - c_step_one;
          clk_en_d   = 1'b1;
        end
      end
      ST_STOPPED: begin
        clk_en_d = 1'b0;
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
        step_rem_d = '0;
      end
    endcase

    if (w_cmd_live) begin
      case (pend_op_q)
        c_op_pause: begin
          state_d    = ST_IDLE;
          clk_en_d   = 1'b0;
          step_rem_d = '0;
        end
        c_op_run: begin
          state_d    = ST_RUN;
          clk_en_d   = !w_stop_hit;
          step_rem_d = '0;
        end
        c_op_step: begin
          // A zero-length step leaves whatever was in progress untouched.
          if (pend_arg_q != '0) begin
            state_d    = ST_STEP;
            step_rem_d = pend_arg_q;
            clk_en_d   = !w_stop_hit;
          end
        end
        default: begin
          state_d     = ST_HOLD;
          clk_en_d    = 1'b0;
          cycle_cnt_d = '0;
          hold_cnt_d  = '0;
          step_rem_d  = '0;
        end
      endcase
    end

    if (!locked_sync_q && (state_q != ST_HOLD)) begin
      state_d     = ST_HOLD;
      clk_en_d    = 1'b0;
      hold_cnt_d  = '0;
      step_rem_d  = '0;
      cycle_cnt_d = w_cycle_cnt_nxt;
    end

    dut_rst_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q       <= ST_HOLD;
      locked_meta_q <= 1'b0;
      locked_sync_q <= 1'b0;
      hold_cnt_q    <= '0;
      step_rem_q    <= '0;
      cycle_cnt_q   <= '0;
      clk_en_q      <= 1'b0;
      dut_rst_q     <= 1'b1;
      pend_q        <= 1'b0;
      pend_op_q     <= '0;
      pend_arg_q    <= '0;
    end else begin
      state_q       <= state_d;
      locked_meta_q <= locked_meta_d;
      locked_sync_q <= locked_sync_d;
      hold_cnt_q    <= hold_cnt_d;
      step_rem_q    <= step_rem_d;
      cycle_cnt_q   <= cycle_cnt_d;
      clk_en_q      <= clk_en_d;
      dut_rst_q     <= dut_rst_d;
      pend_q        <= pend_d;
      pend_op_q     <= pend_op_d;
      pend_arg_q    <= pend_arg_d;
    end
  end

  assign dut_rst     = dut_rst_q;
  assign emu_clk_en  = clk_en_q;
  assign cycle_count = cycle_cnt_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_emu_clk_sched.sv
`default_nettype none
// ============================================================================
// tb_emu_clk_sched : directed run-control sequence with hand-computed results
// Rev 1.0
// ============================================================================
module tb_emu_clk_sched;

  localparam int unsigned STEP_W = 32;
  localparam int unsigned CNT_W  = 64;

  localparam logic [1:0] OP_PAUSE = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  logic             emu_clk;
  logic             emu_rst;
  logic             locked;
  logic             dut_rst;
  logic             emu_clk_en;
  logic [CNT_W-1:0] cycle_count;
  logic [2:0]       state;
`ifdef EMU_STOP_TIME_EN
  logic             stop_en;
  logic [CNT_W-1:0] stop_time;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  emu_clk_sched_if #(.STEP_W(STEP_W)) cmd_if ();

  emu_clk_sched #(
    .RST_CYCLES (16),
    .STEP_W     (STEP_W),
    .CNT_W      (CNT_W)
  ) dut (
    .emu_clk     (emu_clk),
    .emu_rst     (emu_rst),
    .locked      (locked),
    .cmd         (cmd_if),
`ifdef EMU_STOP_TIME_EN
    .stop_en     (stop_en),
    .stop_time   (stop_time),
`endif
    .dut_rst     (dut_rst),
    .emu_clk_en  (emu_clk_en),
    .cycle_count (cycle_count),
    .state       (state)
  );

  initial emu_clk = 1'b0;
  always #5 emu_clk = ~emu_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; the command is accepted on the next rising edge.
  task automatic send(input logic [1:0] op, input logic [31:0] arg);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    @(negedge emu_clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    int         n;
    logic [5:0] pat;
    logic [2:0] st0;

    emu_rst          = 1'b1;
    locked           = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_PAUSE;
    cmd_if.cmd_arg   = '0;
`ifdef EMU_STOP_TIME_EN
    stop_en   = 1'b0;
    stop_time = 64'd7;
`endif
    repeat (3) @(negedge emu_clk);
    check("rst_state", {61'd0, state}, 64'd0);
    check("rst_dut_rst", {63'd0, dut_rst}, 64'd1);
    check("rst_en", {63'd0, emu_clk_en}, 64'd0);
    check("rst_count", cycle_count, 64'd0);
    check("rst_ready", {63'd0, cmd_if.cmd_ready}, 64'd0);

    // 2 sync edges then 16 counted edges: dut_rst seen high after 17 edges.
    emu_rst = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge emu_clk);
      if (dut_rst !== 1'b1) break;
      n++;
    end
    check("hold_len", 64'(n), 64'd17);
    check("idle_state", {61'd0, state}, 64'd1);
    check("idle_en", {63'd0, emu_clk_en}, 64'd0);
    check("idle_ready", {63'd0, cmd_if.cmd_ready}, 64'd1);

    // STEP 5: enable high on the 5 cycles after edges t+1..t+5
    send(OP_STEP, 32'd5);
    check("step5_latency", {63'd0, emu_clk_en}, 64'd0);
    pat = '0;
    st0 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge emu_clk);
      pat[i] = emu_clk_en;
      if (i == 0) st0 = state;
    end
    check("step5_pattern", {58'd0, pat}, 64'h1f);
    check("step5_state_in", {61'd0, st0}, 64'd3);
    check("step5_count", cycle_count, 64'd5);
    check("step5_state_out", {61'd0, state}, 64'd1);

    // RUN, PAUSE accepted 10 edges later -> 10 more enabled cycles
    send(OP_RUN, 32'd0);
    repeat (9) @(negedge emu_clk);
    check("run_state", {61'd0, state}, 64'd2);
    check("run_en", {63'd0, emu_clk_en}, 64'd1);
    send(OP_PAUSE, 32'd0);
    @(negedge emu_clk);
    check("pause_state", {61'd0, state}, 64'd1);
    check("pause_en", {63'd0, emu_clk_en}, 64'd0);
    check("pause_count", cycle_count, 64'd15);

    send(OP_STEP, 32'd0);
    repeat (2) @(negedge emu_clk);
    check("step0_count", cycle_count, 64'd15);
    check("step0_state", {61'd0, state}, 64'd1);

    // STEP 100 reloaded with STEP 3 at the start of the 3rd enabled cycle
    send(OP_STEP, 32'd100);
    repeat (2) @(negedge emu_clk);
    send(OP_STEP, 32'd3);
    @(negedge emu_clk);
    check("reload_state", {61'd0, state}, 64'd3);
    for (int i = 0; i < 30; i++) begin
      if (state === 3'd1) break;
      @(negedge emu_clk);
    end
    check("reload_count", cycle_count, 64'd21);
    check("reload_en", {63'd0, emu_clk_en}, 64'd0);

    // Drop lock at count 38: two sync edges plus the exit edge still count.
    send(OP_RUN, 32'd0);
    for (int i = 0; i < 60; i++) begin
      if (cycle_count === 64'd38) break;
      @(negedge emu_clk);
    end
    locked = 1'b0;
    repeat (6) @(negedge emu_clk);
    check("lost_state", {61'd0, state}, 64'd0);
    check("lost_dut_rst", {63'd0, dut_rst}, 64'd1);
    check("lost_en", {63'd0, emu_clk_en}, 64'd0);
    check("lost_count", cycle_count, 64'd41);
    check("lost_ready", {63'd0, cmd_if.cmd_ready}, 64'd0);

    locked = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge emu_clk);
      if (state !== 3'd0) break;
      n++;
    end
    check("relock_len", 64'(n), 64'd17);
    check("relock_count", cycle_count, 64'd41);
    check("relock_dut_rst", {63'd0, dut_rst}, 64'd0);

    // RESET: lock already synchronised, so HOLD lasts exactly 16 cycles.
    send(OP_RESET, 32'd0);
    @(negedge emu_clk);
    check("reset_state", {61'd0, state}, 64'd0);
    check("reset_count", cycle_count, 64'd0);
    check("reset_dut_rst", {63'd0, dut_rst}, 64'd1);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge emu_clk);
      if (state !== 3'd0) break;
      n++;
    end
    check("reset_hold_len", 64'(n), 64'd16);

`ifdef EMU_STOP_TIME_EN
    stop_en = 1'b1;
    send(OP_RUN, 32'd0);
    for (int i = 0; i < 30; i++) begin
      if (state === 3'd4) break;
      @(negedge emu_clk);
    end
    repeat (2) @(negedge emu_clk);
    check("stop_state", {61'd0, state}, 64'd4);
    check("stop_count", cycle_count, 64'd7);
    check("stop_en_out", {63'd0, emu_clk_en}, 64'd0);
    send(OP_RUN, 32'd0);
    repeat (3) @(negedge emu_clk);
    check("stopped_run_ignored", {61'd0, state}, 64'd4);
    check("stopped_count", cycle_count, 64'd7);
    send(OP_RESET, 32'd0);
    repeat (2) @(negedge emu_clk);
    check("stopped_reset_state", {61'd0, state}, 64'd0);
    check("stopped_reset_count", cycle_count, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
